regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports a_valid / a_ready / a_addr / a_data: in / out / in / in; widths 1 / 1 / ADDR_W / DATA_W; single-cycle (ALU) writeback request.
REQ-006 The block SHALL have ports b_valid / b_ready / b_addr / b_data: in / out / in / in; widths 1 / 1 / ADDR_W / DATA_W; multi-cycle (load/mult) writeback request.
REQ-007 The block SHALL have ports sb_set / sb_addr: in / in; widths 1 / ADDR_W; mark a destination busy when a multi-cycle op issues.
REQ-008 The block SHALL have ports rs1 / rs2: in, ADDR_W each, decode-stage source indices.
REQ-009 The block SHALL have ports rs1_busy / rs2_busy: out, 1 each, combinational scoreboard lookup.
REQ-010 The block SHALL have ports wr_en / wr_addr / wr_data: out; widths 1 / ADDR_W / DATA_W; registered drive of the register-file write port (RegWrite, write index, write_data).

Function
REQ-011 A transfer on a requester SHALL occur when valid and ready are both 1 in the same cycle.
REQ-012 At most one requester SHALL be granted per cycle; ready is 1 only for the granted requester.
REQ-013 With both valid and eligible, grant SHALL be round-robin: the requester not granted last wins.
REQ-014 last_grant SHALL update only on a completed transfer.
REQ-015 A SHALL be ineligible (a_ready=0) while busy[a_addr]=1 and a_addr!=0 (WAW protection).
REQ-016 B SHALL always be eligible.
REQ-017 A transfer accepted in cycle N SHALL drive wr_en=1, wr_addr, wr_data in cycle N+1 (latency 1).
REQ-018 With no transfer in cycle N, wr_en SHALL be 0 in N+1; wr_addr and wr_data hold.
REQ-019 A transfer with addr=0 SHALL be accepted but produce wr_en=0 (register 0 is never written).
REQ-020 sb_set=1 with sb_addr!=0 SHALL set busy[sb_addr] at the next edge; sb_addr=0 is ignored.
REQ-021 A B transfer SHALL clear busy[b_addr] at the same edge it is accepted.
REQ-022 A simultaneous set and clear of the same index SHALL leave it set (set wins).
REQ-023 rsX_busy SHALL equal busy[rsX]; index 0 always reads 0.
REQ-024 No input combination SHALL deadlock: B drains unconditionally, so every busy bit eventually clears.

Reset
REQ-025 While rst=0, wr_en=0, wr_addr=0, wr_data=0, busy=all 0, and last_grant=B (A wins first contention), asynchronously.
REQ-026 Reset asserted mid-operation SHALL discard any accepted-but-unwritten transfer; a_ready and b_ready SHALL read 0 during reset.
REQ-027 After release, the first transfer SHALL be accepted at the first rising edge with rst=1.

Structure
REQ-028 The package regfile_pkg SHALL hold DATA_W/ADDR_W defaults, NUM_REGS=32, and the grant encoding (GNT_A, GNT_B).
REQ-029 The scoreboard SHALL be a sub-module wb_scoreboard (32-bit busy vector, set/clear ports, two lookup ports).
REQ-030 Arbitration and the output register SHALL live in the top module.

Verification
REQ-031 After reset: a_valid=1, a_addr=3, a_data=0x11 -> a_ready=1, next cycle wr_en=1, wr_addr=3, wr_data=0x11.
REQ-032 Both valid for 4 cycles (A addr 4, B addr 5) -> grants A,B,A,B; writes appear one cycle later in that order.
REQ-033 sb_set addr 7, then a_valid addr 7 -> a_ready=0 and rs1=7 gives rs1_busy=1 until B writes addr 7; a_ready=1 the following cycle.
REQ-034 b_valid addr 9 accepted in the same cycle as sb_set addr 9 -> busy[9]=1 afterwards.
REQ-035 a_valid addr 0, data 0xFFFF -> a_ready=1, next-cycle wr_en=0; sb_set addr 0 -> rs1_busy(0)=0.
REQ-036 rst pulsed low the cycle after a B accept -> wr_en=0 immediately, busy cleared, no write to the register file.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   DATA_W_DEF / ADDR_W_DEF : default data and register-index widths
//   NUM_REGS                : number of architectural registers
//   grant_e                 : which requester owns the write port
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

endpackage : regfile_pkg

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard for multi-cycle writebacks.
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   set_en / set_addr      : mark a destination busy (index 0 ignored)
//   clr_en / clr_addr      : clear a destination when its writeback lands
//   rd0_addr / rd0_busy    : combinational lookup port 0
//   rd1_addr / rd1_busy    : combinational lookup port 1
//   busy                   : full busy vector (bit 0 is constant 0)
// A simultaneous set and clear of the same index leaves the bit set.
module wb_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_busy,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_busy,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] busy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        // Register 0 is hardwired, so it can never be outstanding.
        assign busy_reg[gi] = 1'b0;
      end else begin : g_flop
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            busy_reg[gi] <= 1'b0;
          end else if (set_en && (set_addr == ADDR_W'(gi))) begin
            busy_reg[gi] <= 1'b1;
          end else if (clr_en && (clr_addr == ADDR_W'(gi))) begin
            busy_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign busy     = busy_reg;
  assign rd0_busy = busy_reg[rd0_addr];
  assign rd1_busy = busy_reg[rd1_addr];

endmodule : wb_scoreboard

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter between a single-cycle (A) and a multi-cycle (B)
// writeback source, driving a registered register-file write port.
// Ports:
//   clk, rst                          : clock, asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data     : ALU writeback request
//   b_valid/b_ready/b_addr/b_data     : load/mult writeback request
//   sb_set/sb_addr                    : mark destination busy on multi-cycle issue
//   rs1/rs2, rs1_busy/rs2_busy        : decode-stage scoreboard lookups
//   wr_en/wr_addr/wr_data             : registered register-file write port
// A is held off while its destination is still owed a B writeback, so a
// late B result can never overwrite a younger A result. B is never blocked,
// which guarantees every busy bit eventually drains.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0]  busy_vec;
  grant_e            last_grant_reg;
  logic              a_elig;
  logic              grant_a;
  logic              grant_b;
  logic              xfer;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_data;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;

  wb_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set),
    .set_addr (sb_addr),
    .clr_en   (grant_b),
    .clr_addr (b_addr),
    .rd0_addr (rs1),
    .rd0_busy (rs1_busy),
    .rd1_addr (rs2),
    .rd1_busy (rs2_busy),
    .busy     (busy_vec)
  );

  // busy_vec[0] is constant 0, so address 0 is always eligible.
  assign a_elig = a_valid && !busy_vec[a_addr];

  // Grants are gated by rst so neither ready is visible during reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst) begin
      if (a_elig && b_valid) begin
        grant_a = (last_grant_reg == GNT_B);
        grant_b = (last_grant_reg == GNT_A);
      end else begin
        grant_a = a_elig;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // A grant always coincides with valid, so every grant is a transfer.
  assign xfer      = grant_a || grant_b;
  assign xfer_addr = grant_a ? a_addr : b_addr;
  assign xfer_data = grant_a ? a_data : b_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= GNT_B;
    end else if (xfer) begin
      last_grant_reg <= grant_a ? GNT_A : GNT_B;
    end
  end

  // Transfers to register 0 are consumed but never reach the write port;
  // address/data then hold their last written values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      if (xfer && (xfer_addr != '0)) begin
        wr_en_reg   <= 1'b1;
        wr_addr_reg <= xfer_addr;
        wr_data_reg <= xfer_data;
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0, sb_set = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0, sb_addr = '0, rs1 = '0, rs2 = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, rs1_busy, rs2_busy, wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int total = 0;
  int bad   = 0;

  // Reference model state: which registers still owe a B result, who won
  // the last transfer, and what the write port should show.
  bit [31:0]   m_busy;
  bit          m_last_was_a;
  bit          m_wr_en;
  bit [AW-1:0] m_wr_addr;
  bit [DW-1:0] m_wr_data;
  bit          m_win_a, m_win_b;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit reg_busy(input bit [AW-1:0] r);
    return (r != 0) && m_busy[r];
  endfunction

  task automatic model_reset();
    m_busy       = '0;
    m_last_was_a = 1'b0;
    m_wr_en      = 1'b0;
    m_wr_addr    = '0;
    m_wr_data    = '0;
  endtask

  // One clock: check everything on the falling edge, then advance the
  // model at the rising edge and leave 1 time unit for the next drive.
  task automatic run_cycle(input string tag);
    bit a_ok;
    @(negedge clk);
    a_ok = a_valid && !reg_busy(a_addr);
    if (a_ok && b_valid) m_win_a = !m_last_was_a;
    else                 m_win_a = a_ok;
    m_win_b = b_valid && !m_win_a;
    chk({tag, ".a_ready"}, 64'(a_ready), 64'(m_win_a));
    chk({tag, ".b_ready"}, 64'(b_ready), 64'(m_win_b));
    chk({tag, ".rs1_busy"}, 64'(rs1_busy), 64'(reg_busy(rs1)));
    chk({tag, ".rs2_busy"}, 64'(rs2_busy), 64'(reg_busy(rs2)));
    chk({tag, ".wr_en"}, 64'(wr_en), 64'(m_wr_en));
    if (m_wr_en) begin
      chk({tag, ".wr_addr"}, 64'(wr_addr), 64'(m_wr_addr));
      chk({tag, ".wr_data"}, 64'(wr_data), 64'(m_wr_data));
    end
    $display("cyc %s a(v=%0b r=%0b @%0d) b(v=%0b r=%0b @%0d) wr(en=%0b @%0d =%0h)",
             tag, a_valid, a_ready, a_addr, b_valid, b_ready, b_addr, wr_en, wr_addr, wr_data);
    @(posedge clk);
    m_wr_en = 1'b0;
    if (m_win_a || m_win_b) begin
      bit [AW-1:0] ad;
      ad = m_win_a ? a_addr : b_addr;
      if (ad != 0) begin
        m_wr_en   = 1'b1;
        m_wr_addr = ad;
        m_wr_data = m_win_a ? a_data : b_data;
      end
      m_last_was_a = m_win_a;
      if (m_win_b) m_busy[b_addr] = 1'b0;
    end
    if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
    #1;
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; sb_set = 0;
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_wr_en"}, 64'(wr_en), 64'(0));
    chk({tag, ".rst_wr_addr"}, 64'(wr_addr), 64'(0));
    chk({tag, ".rst_wr_data"}, 64'(wr_data), 64'(0));
    chk({tag, ".rst_a_ready"}, 64'(a_ready), 64'(0));
    chk({tag, ".rst_b_ready"}, 64'(b_ready), 64'(0));
    $display("rst %s wr_en=%0b a_ready=%0b b_ready=%0b", tag, wr_en, a_ready, b_ready);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    apply_reset("init");

    // Single A write after reset.
    a_valid = 1; a_addr = 3; a_data = 32'h11;
    run_cycle("a3");
    idle();
    run_cycle("a3_wb");
    chk("a3.wr_addr_lit", 64'(wr_addr), 64'(3));
    chk("a3.wr_data_lit", 64'(wr_data), 64'h11);
    run_cycle("hold");

    // Contention from a fresh reset: A wins first, then alternate.
    apply_reset("rr");
    a_valid = 1; a_addr = 4; a_data = 32'hA0;
    b_valid = 1; b_addr = 5; b_data = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      a_data = 32'hA0 + i; b_data = 32'hB0 + i;
      run_cycle($sformatf("rr%0d", i));
      chk($sformatf("rr%0d.grant_lit", i), 64'(m_win_a), 64'((i % 2) == 0));
    end
    idle();
    run_cycle("rr_tail");

    // Scoreboard blocks A until B delivers the same register.
    sb_set = 1; sb_addr = 7;
    run_cycle("sb7");
    sb_set = 0; rs1 = 7;
    a_valid = 1; a_addr = 7; a_data = 32'hC7;
    run_cycle("a7_blk");
    chk("a7_blk.ready_lit", 64'(a_ready), 64'(0));
    chk("a7_blk.busy_lit", 64'(rs1_busy), 64'(1));
    b_valid = 1; b_addr = 7; b_data = 32'hD7;
    run_cycle("b7");
    b_valid = 0;
    run_cycle("a7_go");
    idle();
    run_cycle("a7_tail");

    // Set and clear of the same register in one cycle: set wins.
    b_valid = 1; b_addr = 9; b_data = 32'h99; sb_set = 1; sb_addr = 9; rs2 = 9;
    run_cycle("set_clr9");
    idle();
    run_cycle("set_clr9_after");
    chk("set_clr9.busy_lit", 64'(rs2_busy), 64'(1));

    // Register 0 writes are absorbed; index 0 is never busy.
    a_valid = 1; a_addr = 0; a_data = 32'hFFFF; sb_set = 1; sb_addr = 0; rs1 = 0;
    run_cycle("a0");
    idle();
    run_cycle("a0_after");
    chk("a0.wr_en_lit", 64'(wr_en), 64'(0));

    // Reset straight after a B accept discards the pending write.
    b_valid = 1; b_addr = 12; b_data = 32'h1234;
    @(negedge clk);
    @(posedge clk);
    idle();
    apply_reset("mid");
    rs1 = 9;
    run_cycle("post_rst");

    // Randomised traffic on a small register window to force conflicts.
    for (int i = 0; i < 400; i++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 2) == 0);
      sb_set  = ($urandom_range(0, 2) == 0);
      a_addr  = AW'($urandom_range(0, 7));
      b_addr  = AW'($urandom_range(0, 7));
      sb_addr = AW'($urandom_range(0, 7));
      rs1     = AW'($urandom_range(0, 7));
      rs2     = AW'($urandom_range(0, 31));
      a_data  = $urandom;
      b_data  = $urandom;
      run_cycle($sformatf("rnd%0d", i));
      if (i == 200) apply_reset("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
